// File: rtl/cpu_types_pkg.sv
// Shared types for the multicycle control unit: FSM states, ALU ops, select encodings, opcodes.
// Optional MC_CU_LLSC_EN adds the LL/SC atomic flag to the decoded control word.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } mccu_state_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BEQ, CLS_BNE, CLS_JUMP, CLS_JAL, CLS_HALT
  } icls_t;

  localparam logic [1:0] PC_NEXT = 2'b00, PC_JUMP = 2'b01, PC_BRANCH = 2'b10, PC_REG = 2'b11;
  localparam logic [1:0] RD_RD = 2'b00, RD_RT = 2'b01, RD_RA = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00, M2R_MEM = 2'b01, M2R_PC4 = 2'b10, M2R_LUI = 2'b11;
  localparam logic [1:0] EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_UPPER = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_LL = 6'h30, OP_SC = 6'h38;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  typedef struct packed {
    icls_t      cls;
    aluop_t     aluop;
    logic       alusrc;
    logic [1:0] extop;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] pcsrc;
    logic       wb_after_mem;
`ifdef MC_CU_LLSC_EN
    logic       atomic;
`endif
  } ctrl_t;

endpackage

// File: rtl/mc_control_unit_if.sv
// Port bundle between the control unit (master) and datapath/memories (slave).
// datomic exists only when MC_CU_LLSC_EN is defined.
interface mc_control_unit_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 32
);
  logic [WORD_W-1:0]     instr;
  logic                  ihit;
  logic                  dhit;
  logic                  zero;
  logic                  iREN;
  logic                  dREN;
  logic                  dWEN;
  logic                  IRWr;
  logic                  PCWr;
  logic                  RegWr;
  logic                  ALUsrc;
  logic [1:0]            RegDst;
  logic [1:0]            PCsrc;
  logic [1:0]            ExtOp;
  logic [1:0]            MemToReg;
  cpu_types_pkg::aluop_t ALUOp;
  logic                  halt;
  logic [CNT_W-1:0]      retired;
  logic [2:0]            state;
`ifdef MC_CU_LLSC_EN
  logic                  datomic;
`endif

  modport master (
    input  instr, ihit, dhit, zero,
`ifdef MC_CU_LLSC_EN
    output datomic,
`endif
    output iREN, dREN, dWEN, IRWr, PCWr, RegWr, ALUsrc,
    output RegDst, PCsrc, ExtOp, MemToReg, ALUOp, halt, retired, state
  );

  modport slave (
    output instr, ihit, dhit, zero,
`ifdef MC_CU_LLSC_EN
    input  datomic,
`endif
    input  iREN, dREN, dWEN, IRWr, PCWr, RegWr, ALUsrc,
    input  RegDst, PCsrc, ExtOp, MemToReg, ALUOp, halt, retired, state
  );
endinterface

// File: rtl/mc_control_unit_decode.sv
// Combinational decode of the latched opcode/funct into static selects and an instruction class.
// LL/SC decode only when MC_CU_LLSC_EN is defined; otherwise they fall to NOP.
module instr_decode
  import cpu_types_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.cls    = CLS_ALU;
        ctrl_o.regdst = RD_RD;
        case (funct_i)
          FN_SLL:  ctrl_o.aluop = ALU_SLL;
          FN_SRL:  ctrl_o.aluop = ALU_SRL;
          FN_ADDU: ctrl_o.aluop = ALU_ADD;
          FN_SUBU: ctrl_o.aluop = ALU_SUB;
          FN_AND:  ctrl_o.aluop = ALU_AND;
          FN_OR:   ctrl_o.aluop = ALU_OR;
          FN_XOR:  ctrl_o.aluop = ALU_XOR;
          FN_NOR:  ctrl_o.aluop = ALU_NOR;
          FN_SLT:  ctrl_o.aluop = ALU_SLT;
          FN_SLTU: ctrl_o.aluop = ALU_SLTU;
          FN_JR: begin
            ctrl_o.cls   = CLS_JUMP;
            ctrl_o.pcsrc = PC_REG;
          end
          default: ctrl_o.cls = CLS_NOP;
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl_o.cls    = CLS_ALU;
        ctrl_o.alusrc = 1'b1;
        ctrl_o.regdst = RD_RT;
        case (opcode_i)
          OP_ADDIU: begin ctrl_o.aluop = ALU_ADD;  ctrl_o.extop = EXT_SIGN; end
          OP_SLTI:  begin ctrl_o.aluop = ALU_SLT;  ctrl_o.extop = EXT_SIGN; end
          OP_SLTIU: begin ctrl_o.aluop = ALU_SLTU; ctrl_o.extop = EXT_SIGN; end
          OP_ANDI:  ctrl_o.aluop = ALU_AND;
          OP_ORI:   ctrl_o.aluop = ALU_OR;
          OP_XORI:  ctrl_o.aluop = ALU_XOR;
          default: begin
            ctrl_o.aluop    = ALU_ADD;
            ctrl_o.extop    = EXT_UPPER;
            ctrl_o.memtoreg = M2R_LUI;
          end
        endcase
      end
      OP_LW: begin
        ctrl_o.cls          = CLS_LOAD;
        ctrl_o.aluop        = ALU_ADD;
        ctrl_o.extop        = EXT_SIGN;
        ctrl_o.alusrc       = 1'b1;
        ctrl_o.regdst       = RD_RT;
        ctrl_o.memtoreg     = M2R_MEM;
        ctrl_o.wb_after_mem = 1'b1;
      end
      OP_SW: begin
        ctrl_o.cls    = CLS_STORE;
        ctrl_o.aluop  = ALU_ADD;
        ctrl_o.extop  = EXT_SIGN;
        ctrl_o.alusrc = 1'b1;
      end
`ifdef MC_CU_LLSC_EN
      OP_LL: begin
        ctrl_o.cls          = CLS_LOAD;
        ctrl_o.aluop        = ALU_ADD;
        ctrl_o.extop        = EXT_SIGN;
        ctrl_o.alusrc       = 1'b1;
        ctrl_o.regdst       = RD_RT;
        ctrl_o.memtoreg     = M2R_MEM;
        ctrl_o.wb_after_mem = 1'b1;
        ctrl_o.atomic       = 1'b1;
      end
      OP_SC: begin
        // SC writes the memory's success result back into rt
        ctrl_o.cls          = CLS_STORE;
        ctrl_o.aluop        = ALU_ADD;
        ctrl_o.extop        = EXT_SIGN;
        ctrl_o.alusrc       = 1'b1;
        ctrl_o.regdst       = RD_RT;
        ctrl_o.memtoreg     = M2R_MEM;
        ctrl_o.wb_after_mem = 1'b1;
        ctrl_o.atomic       = 1'b1;
      end
`endif
      OP_BEQ: begin
        ctrl_o.cls   = CLS_BEQ;
        ctrl_o.aluop = ALU_SUB;
        ctrl_o.extop = EXT_SIGN;
      end
      OP_BNE: begin
        ctrl_o.cls   = CLS_BNE;
        ctrl_o.aluop = ALU_SUB;
        ctrl_o.extop = EXT_SIGN;
      end
      OP_J: begin
        ctrl_o.cls   = CLS_JUMP;
        ctrl_o.pcsrc = PC_JUMP;
      end
      OP_JAL: begin
        ctrl_o.cls      = CLS_JAL;
        ctrl_o.pcsrc    = PC_JUMP;
        ctrl_o.regdst   = RD_RA;
        ctrl_o.memtoreg = M2R_PC4;
      end
      OP_HALT: ctrl_o.cls = CLS_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM: fetch/decode/exec/mem/wb with strobes gated per state and a saturating retire count.
// Define MC_CU_LLSC_EN to enable LL/SC with the datomic output.
module mc_control_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  mc_control_unit_if.master bus
);

  mccu_state_t      state_q, state_d;
  logic [11:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  ctrl_t            ctrl;
  logic             pcwr;
  logic             sel_en;

  // Only opcode and funct drive control, so only those fields are kept in the IR.
  instr_decode u_decode (
    .opcode_i (ir_q[11:6]),
    .funct_i  (ir_q[5:0]),
    .ctrl_o   (ctrl)
  );

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pcwr       = 1'b0;
    bus.iREN   = 1'b0;
    bus.dREN   = 1'b0;
    bus.dWEN   = 1'b0;
    bus.IRWr   = 1'b0;
    bus.RegWr  = 1'b0;
    bus.halt   = 1'b0;
`ifdef MC_CU_LLSC_EN
    bus.datomic = 1'b0;
`endif
    sel_en       = (state_q == EXEC) || (state_q == MEM) || (state_q == WB);
    bus.ALUOp    = sel_en ? ctrl.aluop    : ALU_SLL;
    bus.ALUsrc   = sel_en ? ctrl.alusrc   : 1'b0;
    bus.ExtOp    = sel_en ? ctrl.extop    : EXT_ZERO;
    bus.RegDst   = sel_en ? ctrl.regdst   : RD_RD;
    bus.MemToReg = sel_en ? ctrl.memtoreg : M2R_ALU;
    bus.PCsrc    = sel_en ? ctrl.pcsrc    : PC_NEXT;

    case (state_q)
      FETCH: begin
        bus.iREN = 1'b1;
        if (bus.ihit) begin
          bus.IRWr = 1'b1;
          ir_d     = {bus.instr[WORD_W-1 -: 6], bus.instr[5:0]};
          state_d  = DECODE;
        end
      end
      DECODE: state_d = (ctrl.cls == CLS_HALT) ? HALTED : EXEC;
      EXEC: begin
        case (ctrl.cls)
          CLS_ALU, CLS_JAL:    state_d = WB;
          CLS_LOAD, CLS_STORE: state_d = MEM;
          CLS_BEQ, CLS_BNE: begin
            bus.PCsrc = ((ctrl.cls == CLS_BEQ) == bus.zero) ? PC_BRANCH : PC_NEXT;
            pcwr      = 1'b1;
            state_d   = FETCH;
          end
          default: begin
            pcwr    = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEM: begin
        bus.dREN = (ctrl.cls == CLS_LOAD);
        bus.dWEN = (ctrl.cls == CLS_STORE);
`ifdef MC_CU_LLSC_EN
        bus.datomic = ctrl.atomic;
`endif
        if (bus.dhit) begin
          if (ctrl.wb_after_mem) begin
            state_d = WB;
          end else begin
            pcwr    = 1'b1;
            state_d = FETCH;
          end
        end
      end
      WB: begin
        bus.RegWr = 1'b1;
        pcwr      = 1'b1;
        state_d   = FETCH;
      end
      HALTED: bus.halt = 1'b1;
      default: state_d = FETCH;
    endcase

    bus.PCWr = pcwr;

    // Reset silences everything combinationally so a request in flight drops immediately.
    if (RST) begin
      bus.iREN     = 1'b0;
      bus.dREN     = 1'b0;
      bus.dWEN     = 1'b0;
      bus.IRWr     = 1'b0;
      bus.PCWr     = 1'b0;
      bus.RegWr    = 1'b0;
      bus.halt     = 1'b0;
      bus.ALUOp    = ALU_SLL;
      bus.ALUsrc   = 1'b0;
      bus.ExtOp    = EXT_ZERO;
      bus.RegDst   = RD_RD;
      bus.MemToReg = M2R_ALU;
      bus.PCsrc    = PC_NEXT;
`ifdef MC_CU_LLSC_EN
      bus.datomic  = 1'b0;
`endif
    end
  end

  assign retired_d   = (pcwr && (retired_q != {CNT_W{1'b1}})) ? retired_q + CNT_W'(1) : retired_q;
  assign bus.state   = RST ? FETCH : state_q;
  assign bus.retired = RST ? '0 : retired_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: a retirement scoreboard plus per-cycle strobe checks.
module tb_mc_control_unit;
  import cpu_types_pkg::*;

  localparam int CW = 4;
  localparam logic [31:0] W_ADDIU = 32'h24010005;
  localparam logic [31:0] W_LW    = 32'h8C430004;
  localparam logic [31:0] W_SW    = 32'hAC430008;
  localparam logic [31:0] W_BEQ   = 32'h10220003;
  localparam logic [31:0] W_BNE   = 32'h14220003;
  localparam logic [31:0] W_JAL   = 32'h0C000010;
  localparam logic [31:0] W_JR    = 32'h03E00008;
  localparam logic [31:0] W_NOP   = 32'h40000000;
  localparam logic [31:0] W_HALT  = 32'hFC000000;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mc_control_unit_if #(.WORD_W(32), .CNT_W(CW)) bus();

  mc_control_unit #(.WORD_W(32), .CNT_W(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    string      tag;
    logic [1:0] pcsrc;
    logic       regwr;
    logic [1:0] regdst;
    logic [1:0] m2r;
    logic       alusrc;
    logic [1:0] extop;
    logic [3:0] aluop;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CW-1:0] model_ret = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [1:0] pcsrc, input logic regwr,
                      input logic [1:0] regdst, input logic [1:0] m2r, input logic alusrc,
                      input logic [1:0] extop, input logic [3:0] aluop);
    exp_t e;
    e.tag = tag; e.pcsrc = pcsrc; e.regwr = regwr; e.regdst = regdst;
    e.m2r = m2r; e.alusrc = alusrc; e.extop = extop; e.aluop = aluop;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [31:0] w, input int delay);
    bus.ihit = 1'b0;
    for (int i = 0; i < delay; i++) begin
      @(negedge CLK);
      chk("fetch_iren", bus.iREN, 1);
      chk("fetch_no_irwr", bus.IRWr, 0);
      step();
    end
    bus.instr = w;
    bus.ihit  = 1'b1;
    @(negedge CLK);
    chk("fetch_irwr", bus.IRWr, 1);
    chk("fetch_state", bus.state, FETCH);
    step();
    bus.ihit  = 1'b0;
    bus.instr = W_HALT;
  endtask

  task automatic expect_state(input string tag, input logic [2:0] s);
    @(negedge CLK);
    chk(tag, bus.state, s);
    step();
  endtask

  // Retirement monitor: every PCWr pops one expected instruction.
  always @(negedge CLK) begin
    if (RST) begin
      model_ret = '0;
    end else if (bus.PCWr) begin
      chk("sb_pending", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk({mon_e.tag, "_pcsrc"}, bus.PCsrc, mon_e.pcsrc);
        chk({mon_e.tag, "_regwr"}, bus.RegWr, mon_e.regwr);
        chk({mon_e.tag, "_regdst"}, bus.RegDst, mon_e.regdst);
        chk({mon_e.tag, "_m2r"}, bus.MemToReg, mon_e.m2r);
        chk({mon_e.tag, "_alusrc"}, bus.ALUsrc, mon_e.alusrc);
        chk({mon_e.tag, "_extop"}, bus.ExtOp, mon_e.extop);
        chk({mon_e.tag, "_aluop"}, bus.ALUOp, mon_e.aluop);
        $display("retire %-6s pcsrc=%0d regwr=%0b regdst=%0d m2r=%0d retired=%0d",
                 mon_e.tag, bus.PCsrc, bus.RegWr, bus.RegDst, bus.MemToReg, bus.retired);
      end
      chk("retired_at_pcwr", bus.retired, model_ret);
      if (model_ret != {CW{1'b1}}) model_ret = model_ret + 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.instr = '0;
    bus.ihit  = 1'b0;
    bus.dhit  = 1'b0;
    bus.zero  = 1'b0;

    // reset state
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_state", bus.state, FETCH);
    chk("rst_iren", bus.iREN, 0);
    chk("rst_halt", bus.halt, 0);
    chk("rst_retired", bus.retired, 0);
    chk("rst_pcwr", bus.PCWr, 0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_iren", bus.iREN, 1);
    chk("post_rst_state", bus.state, FETCH);
    chk("post_rst_retired", bus.retired, 0);
    step();

    // ADDIU with ihit on cycle 3, dhit glitching while not awaited
    bus.dhit = 1'b1;
    push("addiu", PC_NEXT, 1, RD_RT, M2R_ALU, 1, EXT_SIGN, ALU_ADD);
    fetch(W_ADDIU, 1);
    expect_state("addiu_decode", DECODE);
    expect_state("addiu_exec", EXEC);
    bus.dhit = 1'b0;
    @(negedge CLK);
    chk("addiu_wb_state", bus.state, WB);
    chk("addiu_wb_regwr", bus.RegWr, 1);
    step();
    @(negedge CLK);
    chk("addiu_retired", bus.retired, 1);
    step();

    // LW with a late dhit
    push("lw", PC_NEXT, 1, RD_RT, M2R_MEM, 1, EXT_SIGN, ALU_ADD);
    fetch(W_LW, 0);
    expect_state("lw_decode", DECODE);
    @(negedge CLK);
    chk("lw_exec_dren", bus.dREN, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("lw_mem_state", bus.state, MEM);
      chk("lw_mem_dren", bus.dREN, 1);
      chk("lw_mem_dwen", bus.dWEN, 0);
      step();
    end
    bus.dhit = 1'b1;
    @(negedge CLK);
    chk("lw_mem_dren_hit", bus.dREN, 1);
    step();
    bus.dhit = 1'b0;
    @(negedge CLK);
    chk("lw_wb_state", bus.state, WB);
    chk("lw_wb_m2r", bus.MemToReg, M2R_MEM);
    step();
    @(negedge CLK);
    chk("lw_retired", bus.retired, 2);
    step();

    // BEQ taken, BNE not taken, both with zero=1
    push("beq", PC_BRANCH, 0, RD_RD, M2R_ALU, 0, EXT_SIGN, ALU_SUB);
    fetch(W_BEQ, 0);
    expect_state("beq_decode", DECODE);
    bus.zero = 1'b1;
    @(negedge CLK);
    chk("beq_pcsrc", bus.PCsrc, PC_BRANCH);
    chk("beq_pcwr", bus.PCWr, 1);
    chk("beq_regwr", bus.RegWr, 0);
    step();
    bus.zero = 1'b0;
    push("bne", PC_NEXT, 0, RD_RD, M2R_ALU, 0, EXT_SIGN, ALU_SUB);
    fetch(W_BNE, 0);
    expect_state("bne_decode", DECODE);
    bus.zero = 1'b1;
    @(negedge CLK);
    chk("bne_pcsrc", bus.PCsrc, PC_NEXT);
    chk("bne_pcwr", bus.PCWr, 1);
    chk("bne_regwr", bus.RegWr, 0);
    step();
    bus.zero = 1'b0;

    // JAL, JR, unrecognised opcode
    push("jal", PC_JUMP, 1, RD_RA, M2R_PC4, 0, EXT_ZERO, ALU_SLL);
    fetch(W_JAL, 0);
    expect_state("jal_decode", DECODE);
    @(negedge CLK);
    chk("jal_exec_pcwr", bus.PCWr, 0);
    step();
    expect_state("jal_wb", WB);
    push("jr", PC_REG, 0, RD_RD, M2R_ALU, 0, EXT_ZERO, ALU_SLL);
    fetch(W_JR, 0);
    expect_state("jr_decode", DECODE);
    expect_state("jr_exec", EXEC);
    push("nop", PC_NEXT, 0, RD_RD, M2R_ALU, 0, EXT_ZERO, ALU_SLL);
    fetch(W_NOP, 0);
    expect_state("nop_decode", DECODE);
    @(negedge CLK);
    chk("nop_pcwr", bus.PCWr, 1);
    chk("nop_regwr", bus.RegWr, 0);
    chk("nop_dren", bus.dREN, 0);
    chk("nop_dwen", bus.dWEN, 0);
    step();

    // HALT, then ihit/dhit toggling, then reset
    fetch(W_HALT, 0);
    expect_state("halt_decode", DECODE);
    for (int i = 0; i < 10; i++) begin
      bus.ihit = i[0];
      bus.dhit = ~i[0];
      @(negedge CLK);
      chk("halted_state", bus.state, HALTED);
      chk("halted_halt", bus.halt, 1);
      chk("halted_iren", bus.iREN, 0);
      chk("halted_irwr", bus.IRWr, 0);
      chk("halted_pcwr", bus.PCWr, 0);
      chk("halted_dren", bus.dREN, 0);
      step();
    end
    bus.ihit = 1'b0;
    bus.dhit = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    chk("halt_rst_state", bus.state, FETCH);
    chk("halt_rst_halt", bus.halt, 0);
    chk("halt_rst_retired", bus.retired, 0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("halt_rst_iren", bus.iREN, 1);
    step();

    // 17 NOPs saturate a 4-bit counter at 15
    for (int n = 0; n < 17; n++) begin
      push("nop_s", PC_NEXT, 0, RD_RD, M2R_ALU, 0, EXT_ZERO, ALU_SLL);
      fetch(W_NOP, 0);
      step();
      step();
    end
    @(negedge CLK);
    chk("sat_retired", bus.retired, 15);
    step();

    // SW with reset asserted mid-MEM
    fetch(W_SW, 0);
    expect_state("sw_decode", DECODE);
    expect_state("sw_exec", EXEC);
    @(negedge CLK);
    chk("sw_mem_dwen", bus.dWEN, 1);
    chk("sw_mem_state", bus.state, MEM);
    step();
    RST = 1'b1;
    @(negedge CLK);
    chk("sw_rst_dwen", bus.dWEN, 0);
    chk("sw_rst_dren", bus.dREN, 0);
    chk("sw_rst_state", bus.state, FETCH);
    chk("sw_rst_retired", bus.retired, 0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("sw_post_rst_iren", bus.iREN, 1);
    step();

    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
